instr_encoder: RTL and testbench

Sequential RV32I instruction encoder: the counterpart to the immediate generator. It accepts a decoded operation (op select, register indices, signed immediate) over a valid/ready handshake and range-checks the immediate. It packs a legal 32-bit machine word and writes it into instruction memory at an auto-incrementing address. It is used by the test/boot loader to fill instruction memory in the same instruction subset the datapath decodes.

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 198 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for the instruction encoder.
// The loader (master) drives decoded operations and clear; the encoder (slave)
// answers with the handshake, the memory write strobe and status.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              clear;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              err;
  logic [15:0]       count;

  modport master (
    output in_valid, op, rd, rs1, rs2, imm, clear,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, count
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, imm, clear,
    output in_ready, mem_we, mem_addr, mem_wdata, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder. Accepts one decoded operation per
// handshake, range-checks its immediate against the 32-bit signed value,
// packs the machine word and writes it to instruction memory at an
// auto-incrementing address. Illegal requests produce a one-cycle err pulse.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            clock,
  input logic            reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_LB  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_BNE = 4'd7;
  localparam logic [3:0] OP_ORI = 4'd8;

  localparam logic [6:0] OPC_REG   = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;

  logic signed [31:0] w_immSigned;
  logic               w_immFitsI;
  logic               w_immFitsB;
  logic [31:0]        w_word;
  logic               w_legal;
  logic               w_inReady;
  logic               w_memWe;
  logic               w_err;
  logic               w_accept;

  // The immediate checks look at the whole 32-bit value so that an out-of-range
  // offset can never be quietly truncated into a legal-looking field.
  assign w_immSigned = r_imm;
  assign w_immFitsI  = (w_immSigned >= -32'sd2048) && (w_immSigned <= 32'sd2047);
  assign w_immFitsB  = (w_immSigned >= -32'sd4096) && (w_immSigned <= 32'sd4094) &&
                       (r_imm[0] == 1'b0);

  // Pack the captured fields into a machine word and decide whether it is legal.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_word  = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, OPC_REG};
        w_legal = 1'b1;
      end
      OP_SUB: begin
        w_word  = {7'b0100000, r_rs2, r_rs1, 3'b000, r_rd, OPC_REG};
        w_legal = 1'b1;
      end
      OP_AND: begin
        w_word  = {7'b0000000, r_rs2, r_rs1, 3'b111, r_rd, OPC_REG};
        w_legal = 1'b1;
      end
      OP_OR: begin
        w_word  = {7'b0000000, r_rs2, r_rs1, 3'b110, r_rd, OPC_REG};
        w_legal = 1'b1;
      end
      OP_SLL: begin
        w_word  = {7'b0000000, r_rs2, r_rs1, 3'b001, r_rd, OPC_REG};
        w_legal = 1'b1;
      end
      OP_LB: begin
        w_word  = {r_imm[11:0], r_rs1, 3'b000, r_rd, OPC_LOAD};
        w_legal = w_immFitsI;
      end
      OP_ORI: begin
        w_word  = {r_imm[11:0], r_rs1, 3'b110, r_rd, OPC_IMM};
        w_legal = w_immFitsI;
      end
      OP_SB: begin
        w_word  = {r_imm[11:5], r_rs2, r_rs1, 3'b000, r_imm[4:0], OPC_STORE};
        w_legal = w_immFitsI;
      end
      OP_BNE: begin
        w_word  = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b001,
                   r_imm[4:1], r_imm[11], OPC_BR};
        w_legal = w_immFitsB;
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Next-state selection and the handshake/strobe outputs decoded from state.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_memWe     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_nextState = ENCODE;
        end
      end
      ENCODE: begin
        if (w_legal) begin
          w_nextState = WRITE;
        end else begin
          w_err       = 1'b1;
          w_nextState = IDLE;
        end
      end
      WRITE: begin
        w_memWe     = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_accept = w_inReady & bus.in_valid;

  // State register; reset aborts whatever operation is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the request fields only on an accepted handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op  <= '0;
      r_rd  <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_imm <= '0;
    end else if (w_accept) begin
      r_op  <= bus.op;
      r_rd  <= bus.rd;
      r_rs1 <= bus.rs1;
      r_rs2 <= bus.rs2;
      r_imm <= bus.imm;
    end
  end

  // Hold the last legal word so write data stays stable through WRITE and after.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdata <= '0;
    end else if ((r_state == ENCODE) && w_legal) begin
      r_wdata <= w_word;
    end
  end

  // Write pointer and word count; clear wins over the post-write increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (bus.clear) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (r_state == WRITE) begin
      r_addr  <= r_addr + ADDR_W'(4);
      r_count <= r_count + 16'd1;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.mem_we    = w_memWe;
  assign bus.err       = w_err;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: hand-computed machine words, cycle
// timing of the handshake, illegal-immediate rejection, clear, reset abort
// and address wrap on a narrow-address instance.
module tb_instr_encoder;

  logic clock;
  logic reset;

  instr_encoder_if #(.ADDR_W(32)) bus ();
  instr_encoder_if #(.ADDR_W(4))  bus2 ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dutWrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int          checkCount;
  int          errorCount;
  int          cycleCount;
  logic [31:0] expAddr;
  logic [15:0] expCount;
  logic [31:0] lastWord;

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to measure write spacing.
  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) at a falling edge until the encoder is ready.
  task automatic waitReady(input string tag);
    int waited;
    waited = 0;
    @(negedge clock);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.in_ready) checkOutput({tag, "_readyTimeout"}, 32'd0, 32'd1);
  endtask

  // Send one request and follow it through ENCODE and WRITE (or rejection).
  task automatic applyStimulus(input string tag, input logic [3:0] opIn,
                               input logic [4:0] rdIn, input logic [4:0] rs1In,
                               input logic [4:0] rs2In, input logic [31:0] immIn,
                               input bit expLegal, input logic [31:0] expWord,
                               input bit clearAtWrite);
    waitReady(tag);
    bus.in_valid = 1'b1;
    bus.op  = opIn;
    bus.rd  = rdIn;
    bus.rs1 = rs1In;
    bus.rs2 = rs2In;
    bus.imm = immIn;
    @(negedge clock);
    bus.in_valid = 1'b0;
    checkOutput({tag, "_encReady"}, {31'd0, bus.in_ready}, 32'd0);
    checkOutput({tag, "_encErr"}, {31'd0, bus.err}, {31'd0, !expLegal});
    checkOutput({tag, "_encWe"}, {31'd0, bus.mem_we}, 32'd0);
    @(negedge clock);
    if (expLegal) begin
      checkOutput({tag, "_we"}, {31'd0, bus.mem_we}, 32'd1);
      checkOutput({tag, "_addr"}, bus.mem_addr, expAddr);
      checkOutput({tag, "_data"}, bus.mem_wdata, expWord);
      if (clearAtWrite) bus.clear = 1'b1;
      @(negedge clock);
      bus.clear = 1'b0;
      if (clearAtWrite) begin
        expAddr  = 32'h0;
        expCount = 16'd0;
      end else begin
        expAddr  = expAddr + 32'd4;
        expCount = expCount + 16'd1;
      end
      lastWord = expWord;
      checkOutput({tag, "_weDone"}, {31'd0, bus.mem_we}, 32'd0);
    end else begin
      checkOutput({tag, "_noWe"}, {31'd0, bus.mem_we}, 32'd0);
      checkOutput({tag, "_errDone"}, {31'd0, bus.err}, 32'd0);
    end
    checkOutput({tag, "_readyAgain"}, {31'd0, bus.in_ready}, 32'd1);
    checkOutput({tag, "_nextAddr"}, bus.mem_addr, expAddr);
    checkOutput({tag, "_count"}, {16'd0, bus.count}, {16'd0, expCount});
    checkOutput({tag, "_hold"}, bus.mem_wdata, lastWord);
  endtask

  task automatic doClear();
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    expAddr  = 32'h0;
    expCount = 16'd0;
    checkOutput("clear_addr", bus.mem_addr, 32'h0);
    checkOutput("clear_count", {16'd0, bus.count}, 32'd0);
  endtask

  initial begin
    int weCycle;
    checkCount = 0;
    errorCount = 0;
    cycleCount = 0;
    expAddr  = 32'h0;
    expCount = 16'd0;
    lastWord = 32'h0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.imm = '0; bus.clear = 1'b0;
    bus2.in_valid = 1'b0; bus2.op = '0; bus2.rd = '0; bus2.rs1 = '0; bus2.rs2 = '0;
    bus2.imm = '0; bus2.clear = 1'b0;

    repeat (2) @(negedge clock);
    checkOutput("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
    checkOutput("rst_count", {16'd0, bus.count}, 32'd0);
    reset = 1'b0;

    applyStimulus("add", 4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3, 1'b0);
    checkOutput("add_addr4", bus.mem_addr, 32'h4);
    checkOutput("add_count1", {16'd0, bus.count}, 32'd1);

    // Back-to-back LB then SB with in_valid held high the whole time.
    waitReady("b2b");
    bus.in_valid = 1'b1;
    bus.op = 4'd5; bus.rd = 5'd5; bus.rs1 = 5'd6; bus.rs2 = 5'd0; bus.imm = -32'sd4;
    @(negedge clock);
    checkOutput("b2b_encReady", {31'd0, bus.in_ready}, 32'd0);
    bus.op = 4'd6; bus.rd = 5'd0; bus.rs1 = 5'd2; bus.rs2 = 5'd7; bus.imm = 32'd8;
    @(negedge clock);
    checkOutput("b2b_lbWe", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("b2b_lbAddr", bus.mem_addr, 32'h4);
    checkOutput("b2b_lbData", bus.mem_wdata, 32'hFFC30283);
    weCycle = cycleCount;
    @(negedge clock);
    checkOutput("b2b_idleReady", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    checkOutput("b2b_sbWe", {31'd0, bus.mem_we}, 32'd1);
    checkOutput("b2b_sbAddr", bus.mem_addr, 32'h8);
    checkOutput("b2b_sbData", bus.mem_wdata, 32'h00710423);
    checkOutput("b2b_gap", cycleCount - weCycle, 32'd3);
    @(negedge clock);
    checkOutput("b2b_doneWe", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("b2b_count", {16'd0, bus.count}, 32'd3);
    expAddr  = 32'hC;
    expCount = 16'd3;
    lastWord = 32'h00710423;

    applyStimulus("bne", 4'd7, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE209CE3, 1'b0);
    applyStimulus("bneOdd", 4'd7, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0, 32'h0, 1'b0);
    applyStimulus("ori2048", 4'd8, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0, 1'b0);
    applyStimulus("op12", 4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0, 1'b0);
    applyStimulus("oriNeg1", 4'd8, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF06093, 1'b0);
    checkOutput("oriNeg1_addr", bus.mem_addr, 32'h14);

    applyStimulus("sub", 4'd1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h403100B3, 1'b0);
    applyStimulus("and", 4'd2, 5'd4, 5'd5, 5'd6, 32'hDEADBEEF, 1'b1, 32'h0062F233, 1'b0);
    applyStimulus("or", 4'd3, 5'd31, 5'd31, 5'd31, 32'h0, 1'b1, 32'h01FFEFB3, 1'b0);
    applyStimulus("sll", 4'd4, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 32'h00001033, 1'b0);
    applyStimulus("ori2047", 4'd8, 5'd0, 5'd0, 5'd9, 32'd2047, 1'b1, 32'h7FF06013, 1'b0);
    applyStimulus("lbMin", 4'd5, 5'd0, 5'd0, 5'd9, -32'sd2048, 1'b1, 32'h80000003, 1'b0);
    applyStimulus("sbMax", 4'd6, 5'd9, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7E000FA3, 1'b0);
    applyStimulus("bneMax", 4'd7, 5'd9, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E001FE3, 1'b0);
    applyStimulus("bneMin", 4'd7, 5'd0, 5'd0, 5'd0, -32'sd4096, 1'b1, 32'h80001063, 1'b0);
    applyStimulus("bne4096", 4'd7, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0, 1'b0);
    applyStimulus("sbBelow", 4'd6, 5'd0, 5'd0, 5'd0, -32'sd2049, 1'b0, 32'h0, 1'b0);
    applyStimulus("lbHuge", 4'd5, 5'd0, 5'd0, 5'd0, 32'h00010000, 1'b0, 32'h0, 1'b0);
    applyStimulus("op15", 4'd15, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Clear during the WRITE of the third word after a fresh start.
    doClear();
    applyStimulus("clr1", 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003100B3, 1'b0);
    applyStimulus("clr2", 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003100B3, 1'b0);
    applyStimulus("clr3", 4'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, 32'h002081B3, 1'b1);
    applyStimulus("clrNext", 4'd8, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF06093, 1'b0);
    checkOutput("clrNext_count1", {16'd0, bus.count}, 32'd1);

    // Reset asserted during ENCODE aborts the write.
    waitReady("rstEnc");
    bus.in_valid = 1'b1;
    bus.op = 4'd0; bus.rd = 5'd3; bus.rs1 = 5'd1; bus.rs2 = 5'd2; bus.imm = '0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("rstEnc_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rstEnc_we", {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rstEnc_err", {31'd0, bus.err}, 32'd0);
    checkOutput("rstEnc_addr", bus.mem_addr, 32'h0);
    checkOutput("rstEnc_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rstEnc_count", {16'd0, bus.count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rstEnc_noWe", {31'd0, bus.mem_we}, 32'd0);
    end
    expAddr  = 32'h0;
    expCount = 16'd0;
    lastWord = 32'h0;

    // Narrow-address instance: five writes walk 0,4,8,C and wrap to 0.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus2.in_valid = 1'b1;
      bus2.op = 4'd0; bus2.rd = 5'd1; bus2.rs1 = 5'd1; bus2.rs2 = 5'd1;
      @(negedge clock);
      bus2.in_valid = 1'b0;
      @(negedge clock);
      checkOutput("wrap_we", {31'd0, bus2.mem_we}, 32'd1);
      checkOutput("wrap_addr", {28'd0, bus2.mem_addr}, (i * 4) % 16);
      @(negedge clock);
    end
    checkOutput("wrap_finalAddr", {28'd0, bus2.mem_addr}, 32'h4);
    checkOutput("wrap_count", {16'd0, bus2.count}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
